// File: rtl/dmem_bus_master.sv
// ---------------------------------------------------------------------------
// dmem_bus_master
// MEM-stage data-memory initiator. Converts one load/store held by the MEM
// stage into a req/gnt address phase followed, for loads, by an rvalid data
// phase. Holds mem_stall_o until the access completes and returns load data
// towards MEM/WB.
//
// Optional build macro: DMEM_TIMEOUT_EN
//   defined   : a 16-bit watchdog aborts an access stuck in ADDR/WAIT after
//               TIMEOUT_CYCLES cycles and pulses bus_err_o in the DONE cycle.
//   undefined : ADDR/WAIT wait indefinitely, bus_err_o is tied low.
// ---------------------------------------------------------------------------
module dmem_bus_master #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    // MEM-stage request
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [3:0]        req_be,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    // pipeline side
    output logic              mem_stall_o,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid_o,
    output logic              bus_err_o,
    // data bus
    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    // Reject watchdog limits the 16-bit counter cannot represent.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("dmem_bus_master: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_timeout;      // watchdog limit reached this cycle
    logic        w_timeout_hit;  // watchdog actually forces the move to DONE
    logic        w_err;          // DONE cycle of a watchdog-aborted access
    logic        r_abandon;      // req_valid dropped after the request was latched
    logic [31:0] r_rdata;

    // State register.
    // NOTE: the reset is asynchronous, so rst sits in the sensitivity list;
    // bus_req and mem_stall_o follow r_state and drop without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: state elements use non-blocking assignments so every
            // flop samples the pre-edge values of the others.
            r_state <= w_next;
        end
    end

    // Next-state decode; gnt/rvalid take priority over a simultaneous timeout.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        w_next        = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus_gnt) begin
                    // stores are posted: no data phase to wait for
                    w_next = bus_we ? ST_DONE : ST_WAIT;
                end else if (w_timeout) begin
                    w_next        = ST_DONE;
                    w_timeout_hit = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus_rvalid) begin
                    w_next = ST_DONE;
                end else if (w_timeout) begin
                    w_next        = ST_DONE;
                    w_timeout_hit = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Latch the request in IDLE; the fields stay frozen for the whole access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_we    <= 1'b0;
            bus_be    <= 4'b0;
            bus_addr  <= '0;
            bus_wdata <= 32'b0;
        end else if (r_state == ST_IDLE && req_valid) begin
            bus_we    <= req_we;
            bus_be    <= req_be;
            bus_addr  <= req_addr;
            bus_wdata <= req_wdata;
        end
    end

    // Load data capture and tracking of a request withdrawn mid-access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata   <= 32'b0;
            r_abandon <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_abandon <= 1'b0;
            end else if ((r_state == ST_ADDR || r_state == ST_WAIT) && !req_valid) begin
                r_abandon <= 1'b1;
            end

            // rvalid outside WAIT is a protocol error and is ignored
            if (r_state == ST_WAIT && bus_rvalid) begin
                r_rdata <= bus_rdata;
            end else if (w_timeout_hit) begin
                r_rdata <= 32'b0;
            end
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_cnt;
    logic        r_timed_out;

    // Watchdog: counts ADDR+WAIT cycles, zero on entry to ADDR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 16'd0;
            r_timed_out <= 1'b0;
        end else begin
            if (r_state == ST_ADDR || r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 16'd1;
            end else begin
                r_cnt <= 16'd0;
            end
            r_timed_out <= w_timeout_hit;
        end
    end

    // The cycle that completes TIMEOUT_CYCLES of waiting ends the access.
    assign w_timeout = (r_cnt == LP_TO_LAST);
    assign w_err     = (r_state == ST_DONE) && r_timed_out;
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    assign bus_req       = (r_state == ST_ADDR);
    assign mem_stall_o   = req_valid && (r_state != ST_DONE);
    assign rdata_o       = r_rdata;
    assign rdata_valid_o = (r_state == ST_DONE) && !bus_we && req_valid
                           && !r_abandon && !w_err;
    assign bus_err_o     = w_err;

endmodule

// File: tb/tb_dmem_bus_master.sv
// ---------------------------------------------------------------------------
// tb_dmem_bus_master
// Directed bench for dmem_bus_master: single load, slow store, back-to-back
// load/store, reset in ADDR and WAIT, request withdrawn during WAIT, and the
// watchdog (DMEM_TIMEOUT_EN) or an indefinite wait (default build).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_dmem_bus_master;

    localparam int TB_ADDR_W  = 32;
    localparam int TB_TIMEOUT = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_we;
    logic [3:0]           req_be;
    logic [TB_ADDR_W-1:0] req_addr;
    logic [31:0]          req_wdata;
    logic                 mem_stall_o;
    logic [31:0]          rdata_o;
    logic                 rdata_valid_o;
    logic                 bus_err_o;
    logic                 bus_req;
    logic                 bus_we;
    logic [3:0]           bus_be;
    logic [TB_ADDR_W-1:0] bus_addr;
    logic [31:0]          bus_wdata;
    logic                 bus_gnt;
    logic                 bus_rvalid;
    logic [31:0]          bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_bus_master #(
        .ADDR_W        (TB_ADDR_W),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_be       (req_be),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_stall_o  (mem_stall_o),
        .rdata_o      (rdata_o),
        .rdata_valid_o(rdata_valid_o),
        .bus_err_o    (bus_err_o),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_be       (bus_be),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_gnt      (bus_gnt),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Runs one access from its IDLE cycle to its DONE (release) cycle and
    // returns in DONE, before the next rising edge. Grants on the ADDR cycle
    // following gnt_wait idle ADDR cycles; loads get rvalid the cycle after
    // gnt. req_* are scrambled while stalled to prove they are ignored.
    task automatic do_access(input string tag, input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int gnt_wait, input logic [31:0] rd,
                             output int n_stall, output int n_req,
                             output int n_rv, output int n_lead);
        logic gnt_given;
        logic rv_sent;
        logic done;
        n_stall = 0; n_req = 0; n_rv = 0; n_lead = 0;
        gnt_given = 1'b0; rv_sent = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            if (cyc == 0) begin
                req_valid = 1'b1;
                req_we    = we;
                req_be    = be;
                req_addr  = addr;
                req_wdata = wdata;
            end else begin
                req_we    = ~we;
                req_be    = ~be;
                req_addr  = ~addr;
                req_wdata = ~wdata;
            end
            if (gnt_given && !we && !rv_sent) begin
                bus_rvalid = 1'b1;
                bus_rdata  = rd;
                rv_sent    = 1'b1;
            end
            #1;
            if (bus_req) begin
                n_req++;
                check({tag, "_bus_addr"},  64'(bus_addr),  64'(addr));
                check({tag, "_bus_we"},    64'(bus_we),    64'(we));
                check({tag, "_bus_be"},    64'(bus_be),    64'(be));
                check({tag, "_bus_wdata"}, 64'(bus_wdata), 64'(wdata));
                if (n_req > gnt_wait) begin
                    bus_gnt   = 1'b1;
                    gnt_given = 1'b1;
                end
            end else if (n_req == 0) begin
                n_lead++;
            end
            if (mem_stall_o)   n_stall++;
            if (rdata_valid_o) n_rv++;
            if (!mem_stall_o)  done = 1'b1;
        end
        if (!done) check({tag, "_released_in_budget"}, 64'(0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "tb_dmem_bus_master watchdog expired");
    end

    initial begin
        int ns, nr, nv, nl;
        int n_err;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
        req_addr = '0; req_wdata = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;

        // ---- reset state ----
        #1;
        check("rst_bus_req",     64'(bus_req),       64'(0));
        check("rst_stall",       64'(mem_stall_o),   64'(0));
        check("rst_rdata_valid", 64'(rdata_valid_o), 64'(0));
        check("rst_bus_err",     64'(bus_err_o),     64'(0));
        check("rst_rdata",       64'(rdata_o),       64'(0));
        check("rst_bus_addr",    64'(bus_addr),      64'(0));
        check("rst_bus_fields",  64'({bus_we, bus_be, bus_wdata}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---- 1: load 0x100, gnt at once, rvalid next cycle ----
        do_access("t1", 1'b0, 4'hF, 32'h100, 32'h0, 0, 32'hDEADBEEF, ns, nr, nv, nl);
        check("t1_stall_cycles", 64'(ns), 64'(3));
        check("t1_req_cycles",   64'(nr), 64'(1));
        check("t1_rv_in_done",   64'(rdata_valid_o), 64'(1));
        check("t1_rv_pulses",    64'(nv), 64'(1));
        check("t1_rdata",        64'(rdata_o), 64'hDEADBEEF);
        check("t1_req_low_done", 64'(bus_req), 64'(0));
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("t1_rv_after",     64'(rdata_valid_o), 64'(0));
        check("t1_rdata_hold",   64'(rdata_o), 64'hDEADBEEF);

        // ---- 2: store 0x204 be=0011, gnt after 4 wait cycles ----
        do_access("t2", 1'b1, 4'b0011, 32'h204, 32'h0000ABCD, 4, 32'h0, ns, nr, nv, nl);
        check("t2_req_cycles",   64'(nr), 64'(5));
        check("t2_stall_cycles", 64'(ns), 64'(6));
        check("t2_no_rv",        64'(nv), 64'(0));
        check("t2_rdata_kept",   64'(rdata_o), 64'hDEADBEEF);

        // ---- 3: load then store back-to-back, req_valid held ----
        do_access("t3a", 1'b0, 4'hF, 32'h300, 32'h0, 0, 32'hCAFEF00D, ns, nr, nv, nl);
        check("t3a_lead_idle",   64'(nl), 64'(1));
        check("t3a_stall",       64'(ns), 64'(3));
        check("t3a_rdata",       64'(rdata_o), 64'hCAFEF00D);
        check("t3a_req_low_done",64'(bus_req), 64'(0));
        do_access("t3b", 1'b1, 4'b1100, 32'h304, 32'h55AA0000, 0, 32'h0, ns, nr, nv, nl);
        check("t3b_lead_idle",   64'(nl), 64'(1));
        check("t3b_stall",       64'(ns), 64'(2));
        check("t3b_no_rv",       64'(nv), 64'(0));
        @(negedge clk);
        req_valid = 1'b0;

        // ---- 4: reset in WAIT, then in ADDR ----
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF; req_addr = 32'h400;
        @(negedge clk);
        #1;
        check("t4_in_addr",      64'(bus_req), 64'(1));
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        #1;
        check("t4_wait_stall",   64'(mem_stall_o), 64'(1));
        rst = 1'b1; req_valid = 1'b0;
        #1;
        check("t4_rst_req",      64'(bus_req), 64'(0));
        check("t4_rst_stall",    64'(mem_stall_o), 64'(0));
        check("t4_rst_rdata",    64'(rdata_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hBAD0BAD0;
        #1;
        check("t4_late_rv",      64'(rdata_valid_o), 64'(0));
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        check("t4_late_rdata",   64'(rdata_o), 64'(0));
        check("t4_late_req",     64'(bus_req), 64'(0));
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h440;
        @(negedge clk);
        #1;
        check("t4b_in_addr",     64'(bus_req), 64'(1));
        rst = 1'b1; req_valid = 1'b0;
        #1;
        check("t4b_async_drop",  64'(bus_req), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        do_access("t4c", 1'b0, 4'hF, 32'h500, 32'h0, 1, 32'h0A0B0C0D, ns, nr, nv, nl);
        check("t4c_stall",       64'(ns), 64'(4));
        check("t4c_rv",          64'(nv), 64'(1));
        check("t4c_rdata",       64'(rdata_o), 64'h0A0B0C0D);
        @(negedge clk);
        req_valid = 1'b0;

        // ---- 6: req_valid dropped during WAIT ----
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF; req_addr = 32'h600;
        @(negedge clk);
        #1;
        check("t6_in_addr",      64'(bus_req), 64'(1));
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0; req_valid = 1'b0;
        #1;
        check("t6_no_stall",     64'(mem_stall_o), 64'(0));
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        #1;
        check("t6_rv_wait",      64'(rdata_valid_o), 64'(0));
        @(negedge clk);
        bus_rvalid = 1'b0;
        #1;
        check("t6_rv_done",      64'(rdata_valid_o), 64'(0));
        check("t6_rdata",        64'(rdata_o), 64'h12345678);
        @(negedge clk);
        #1;
        check("t6_idle_req",     64'(bus_req), 64'(0));
        do_access("t6b", 1'b1, 4'hF, 32'h604, 32'h01020304, 0, 32'h0, ns, nr, nv, nl);
        check("t6b_lead_idle",   64'(nl), 64'(1));
        check("t6b_stall",       64'(ns), 64'(2));
        @(negedge clk);
        req_valid = 1'b0;

`ifdef DMEM_TIMEOUT_EN
        // ---- 5: watchdog, gnt never asserted ----
        n_err = 0; nr = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF; req_addr = 32'h800;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            #1;
            if (bus_req) nr++;
            if (bus_err_o) begin
                n_err++;
                check("t5_err_rdata",  64'(rdata_o), 64'(0));
                check("t5_err_no_rv",  64'(rdata_valid_o), 64'(0));
            end
            if (!mem_stall_o) break;
        end
        check("t5_addr_cycles",  64'(nr), 64'(TB_TIMEOUT));
        check("t5_err_pulses",   64'(n_err), 64'(1));
        check("t5_released",     64'(mem_stall_o), 64'(0));
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("t5_err_cleared",  64'(bus_err_o), 64'(0));
`else
        // ---- 5 (watchdog absent): long gnt wait is never aborted ----
        n_err = 0;
        do_access("t5", 1'b1, 4'hF, 32'h900, 32'hFEEDFACE, 11, 32'h0, ns, nr, nv, nl);
        check("t5_req_cycles",   64'(nr), 64'(12));
        check("t5_stall",        64'(ns), 64'(13));
        check("t5_no_err",       64'(bus_err_o), 64'(n_err));
        @(negedge clk);
        req_valid = 1'b0;
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
